// File: rtl/anim_step_sequencer.sv
// Step index generator for the digit and animation decoders.
// A programmable prescaler produces auto step ticks. A mode-dependent modulo counter advances
// on each tick, either free-running or manually stepped. All outputs are registered.
module anim_step_sequencer #(
    parameter int unsigned PRESC_W  = 24,
    parameter int unsigned DIV_BASE = 50000
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [2:0] mode_i,
    input  logic [2:0] speed_i,
    input  logic       run_i,
    input  logic       dir_i,
    input  logic       step_req_i,
    output logic [3:0] counter_o,
    output logic [2:0] mode_out_o,
    output logic       step_stb_o,
    output logic       wrap_stb_o
);

    // Sequence length per mode; reserved modes report 0 and are never stepped.
    function automatic logic [3:0] seq_len(input logic [2:0] m);
        logic [3:0] len;
        unique case (m)
            3'd0:                len = 4'd10;
            3'd1, 3'd2, 3'd3:    len = 4'd7;
            3'd4, 3'd5:          len = 4'd6;
            default:             len = 4'd0;
        endcase
        return len;
    endfunction

    function automatic logic is_reserved(input logic [2:0] m);
        return m[2] & m[1];
    endfunction

    logic [PRESC_W-1:0] presc_q;
    logic [PRESC_W-1:0] limit;
    logic [3:0]         counter_q;
    logic [3:0]         last_idx;
    logic [2:0]         mode_out_q;
    logic               step_stb_q;
    logic               wrap_stb_q;
    logic               step_req_q;
    logic               man_tick_q;
    logic               auto_tick;
    logic               tick;

    // Prescaler terminal count and the combined auto/manual step tick.
    always_comb begin
        limit     = PRESC_W'((DIV_BASE << speed_i) - 32'd1);
        auto_tick = run_i && (presc_q >= limit);
        tick      = auto_tick || man_tick_q;
        last_idx  = seq_len(mode_out_q) - 4'd1;
    end

    // Prescaler, manual edge detect, mode tracking and the step counter with its strobes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            presc_q    <= '0;
            counter_q  <= 4'd0;
            mode_out_q <= 3'd0;
            step_stb_q <= 1'b0;
            wrap_stb_q <= 1'b0;
            step_req_q <= 1'b0;
            man_tick_q <= 1'b0;
        end else begin
            step_req_q <= step_req_i;
            // Registered edge pulse gives the two-cycle manual step latency.
            man_tick_q <= step_req_i & ~step_req_q & ~run_i;
            step_stb_q <= 1'b0;
            wrap_stb_q <= 1'b0;
            if (mode_i != mode_out_q) begin
                // Mode change wins over any coincident tick, which is dropped.
                mode_out_q <= mode_i;
                presc_q    <= '0;
                if (is_reserved(mode_i)) begin
                    counter_q <= 4'hF;
                end else if (dir_i) begin
                    counter_q <= 4'd0;
                end else begin
                    counter_q <= seq_len(mode_i) - 4'd1;
                end
            end else begin
                if (!run_i || auto_tick) begin
                    presc_q <= '0;
                end else begin
                    presc_q <= presc_q + 1'b1;
                end
                if (is_reserved(mode_out_q)) begin
                    counter_q <= 4'hF;
                end else if (tick) begin
                    step_stb_q <= 1'b1;
                    if (dir_i) begin
                        if (counter_q == last_idx) begin
                            counter_q  <= 4'd0;
                            wrap_stb_q <= 1'b1;
                        end else begin
                            counter_q <= counter_q + 4'd1;
                        end
                    end else begin
                        if (counter_q == 4'd0) begin
                            counter_q  <= last_idx;
                            wrap_stb_q <= 1'b1;
                        end else begin
                            counter_q <= counter_q - 4'd1;
                        end
                    end
                end
            end
        end
    end

    assign counter_o  = counter_q;
    assign mode_out_o = mode_out_q;
    assign step_stb_o = step_stb_q;
    assign wrap_stb_o = wrap_stb_q;

endmodule

// File: doc/anim_step_sequencer.md
Name: anim_step_sequencer

Overview:
Generates the 4-bit step index that drives the seven-segment digit decoder and the animation pattern decoders.
- A programmable prescaler turns the system clock into step ticks.
- A mode-dependent modulo step counter advances on each tick, either free-running or manually stepped.
- Outputs are the registered step index, the active mode, a step strobe and a wrap strobe for the downstream decoder mux and top-level logic.

Parameters:
- PRESC_W, 24, prescaler counter width; must hold (DIV_BASE << 7) - 1.
- DIV_BASE, 50000, clock cycles per step at speed = 0.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- mode  input  3  pattern select: 0 = digits, 1-3 = 7-step animations, 4-5 = 6-step animations, 6-7 = reserved
- speed  input  3  step period = DIV_BASE << speed cycles
- run  input  1  1 = free-running, 0 = paused / manual stepping
- dir  input  1  1 = count up, 0 = count down
- step_req  input  1  manual step request; rising-edge detected, honoured only when run = 0
- counter  output  4  step index to the decoders
- mode_out  output  3  active (registered) mode
- step_stb  output  1  one-cycle pulse in the cycle the counter changes by stepping
- wrap_stb  output  1  one-cycle pulse when a step wraps the sequence

Behaviour:
- Reset (async assert, sync release): prescaler = 0, counter = 0, mode_out = 0, step_stb = 0, wrap_stb = 0, step_req edge register = 0.
- Sequence length LEN(mode_out): 0 -> 10; 1, 2, 3 -> 7; 4, 5 -> 6; 6, 7 -> reserved.
- Limit computation: limit = (DIV_BASE << speed) - 1, evaluated combinationally each cycle at PRESC_W bits.
- Prescaler, run = 1:
  - increments every cycle;
  - when prescaler >= limit, it clears to 0 and asserts an internal tick;
  - a speed change that lowers limit below the current prescaler value therefore ticks on the next cycle.
- Prescaler, run = 0: held at 0.
- Manual step: step_req is registered every cycle. The manual tick is (step_req & ~step_req_q & ~run). step_req rising edges while run = 1 are ignored.
- Step on a tick (auto or manual):
  - up: counter == LEN-1 -> 0 and wrap_stb = 1; otherwise counter + 1.
  - down: counter == 0 -> LEN-1 and wrap_stb = 1; otherwise counter - 1.
  - step_stb = 1 in the same cycle the new counter value becomes visible.
  - Both strobes are registered and last exactly one cycle.
- Mode change (mode != mode_out, sampled each cycle):
  - next cycle: mode_out <= mode, prescaler <= 0;
  - counter <= 0 if dir = 1, else LEN(new mode) - 1;
  - no step_stb or wrap_stb.
  - Mode change has priority over a coincident tick; that tick is discarded.
- Reserved modes 6/7: counter forced to 4'hF, which decoders render as blank. Prescaler keeps running but step_stb and wrap_stb stay 0. Leaving a reserved mode follows the mode-change rule.
- Direction change: takes effect on the next step only. No reload and no strobe.
- Invariant: in valid modes counter is always < LEN(mode_out).
- Latency:
  - auto step: counter updates 1 cycle after the tick condition;
  - manual step: 2 cycles after the step_req rise (edge register, then counter update).
- Reset asserted mid-sequence returns all state to the reset values immediately, regardless of clk.

Test Plan (DIV_BASE = 4, PRESC_W = 12):
1. Reset, mode = 0, speed = 0, run = 1, dir = 1 -> counter steps 0..9 every 4 cycles, then 9 -> 0 with wrap_stb = 1 for one cycle; step_stb pulses every 4 cycles.
2. mode = 1, dir = 0 -> one cycle later mode_out = 1 and counter = 6; counter then steps 6, 5, ..., 0, 6, with wrap_stb on the 0 -> 6 transition.
3. mode = 4, dir = 1, speed = 2 -> step period 16 cycles, sequence 0..5 then wrap. Switching speed 2 -> 0 while prescaler = 10 -> tick on the next cycle.
4. run = 0, three step_req rising edges separated by 5 cycles, plus step_req held high 20 cycles -> exactly three steps, each 2 cycles after its edge. step_req pulses with run = 1 cause no extra steps.
5. mode = 6 -> counter = 4'hF, no strobes for 100 cycles. Then mode = 0 -> counter = 0 and stepping resumes.
6. Mode change in the same cycle as a prescaler tick at counter = 3 -> counter = 0, no step_stb. rst_n pulsed low mid-count (no clk edge) -> all outputs 0 immediately.
